// File: rtl/alu_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_control_sequencer
// Brief    : Moore control unit that sequences DataPath fetch (T0-T2) and
//            register-register ALU execute (T3-T6); optional SINGLE_STEP_EN
//            macro adds a step port that gates every state transition.
// Revision : 1.0 - initial release
// ============================================================================
module alu_control_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             run,
  input  logic             mem_rdy,
  input  logic [31:0]      ir,
`ifdef SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic [15:0]      Rin,
  output logic [15:0]      Rout,
  output logic             PCout,
  output logic             PCin,
  output logic             incPC,
  output logic             MARin,
  output logic             MDRin,
  output logic             read,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             Zin,
  output logic             ZLowOut,
  output logic             ZHighOut,
  output logic             HIin,
  output logic             LOin,
  output logic [4:0]       opcode,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [4:0] c_op_add  = 5'b00011;
  localparam logic [4:0] c_op_sub  = 5'b00100;
  localparam logic [4:0] c_op_and  = 5'b00101;
  localparam logic [4:0] c_op_or   = 5'b00110;
  localparam logic [4:0] c_op_shr  = 5'b00111;
  localparam logic [4:0] c_op_shra = 5'b01000;
  localparam logic [4:0] c_op_shl  = 5'b01001;
  localparam logic [4:0] c_op_ror  = 5'b01010;
  localparam logic [4:0] c_op_rol  = 5'b01011;
  localparam logic [4:0] c_op_mul  = 5'b01111;
  localparam logic [4:0] c_op_div  = 5'b10000;
  localparam logic [4:0] c_op_neg  = 5'b10001;
  localparam logic [4:0] c_op_not  = 5'b10010;
  localparam logic [4:0] c_op_nop  = 5'b11010;
  localparam logic [4:0] c_op_halt = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               illegal_q, illegal_d;

  logic [4:0]         op;
  logic [15:0]        ra_oh, rb_oh, rc_oh;
  logic               is_alu, is_unary, is_muldiv, is_nop, is_halt;
  logic               adv;
  logic               unused_ir_bits;

  assign op             = ir[31:27];
  assign ra_oh          = 16'h0001 << ir[26:23];
  assign rb_oh          = 16'h0001 << ir[22:19];
  assign rc_oh          = 16'h0001 << ir[18:15];
  assign unused_ir_bits = ^ir[14:0];

`ifdef SINGLE_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  always_comb begin
    is_alu    = 1'b0;
    is_unary  = 1'b0;
    is_muldiv = 1'b0;
    is_nop    = 1'b0;
    is_halt   = 1'b0;
    case (op)
      c_op_add, c_op_sub, c_op_and, c_op_or, c_op_shr,
      c_op_shra, c_op_shl, c_op_ror, c_op_rol: is_alu = 1'b1;
      c_op_mul, c_op_div: begin
        is_alu    = 1'b1;
        is_muldiv = 1'b1;
      end
      c_op_neg, c_op_not: begin
        is_alu   = 1'b1;
        is_unary = 1'b1;
      end
      c_op_nop:  is_nop  = 1'b1;
      c_op_halt: is_halt = 1'b1;
      default: ;
    endcase
  end

  // Next state; every retirement (nop at T3, ALU at T5/T6) bumps the counter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    if (adv) begin
      case (state_q)
        S_IDLE: if (run) state_d = S_T0;
        S_T0:   state_d = S_T1;
        S_T1:   if (mem_rdy) state_d = S_T2;
        S_T2:   state_d = S_T3;
        S_T3: begin
          if (is_alu) begin
            state_d = S_T4;
          end else if (is_nop) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = run ? S_T0 : S_IDLE;
          end else if (is_halt) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = S_HALT;
          end else begin
            illegal_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
        S_T4:   state_d = S_T5;
        S_T5: begin
          if (is_muldiv) begin
            state_d = S_T6;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = run ? S_T0 : S_IDLE;
          end
        end
        S_T6: begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = run ? S_T0 : S_IDLE;
        end
        S_HALT: state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  // Controls depend on state_q plus the IR fields, which are stable from T3 on.
  always_comb begin
    Rin      = '0;
    Rout     = '0;
    PCout    = 1'b0;
    PCin     = 1'b0;
    incPC    = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    read     = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    ZLowOut  = 1'b0;
    ZHighOut = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    opcode   = '0;
    busy     = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_T0: begin
        busy  = 1'b1;
        PCout = 1'b1;
        MARin = 1'b1;
        incPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        busy    = 1'b1;
        ZLowOut = 1'b1;
        PCin    = 1'b1;
        read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        busy   = 1'b1;
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        busy = 1'b1;
        if (is_alu) begin
          Rout = rb_oh;
          Yin  = 1'b1;
        end
      end
      S_T4: begin
        busy   = 1'b1;
        Rout   = is_unary ? rb_oh : rc_oh;
        opcode = op;
        Zin    = 1'b1;
      end
      S_T5: begin
        busy    = 1'b1;
        ZLowOut = 1'b1;
        if (is_muldiv) LOin = 1'b1;
        else           Rin  = ra_oh;
      end
      S_T6: begin
        busy     = 1'b1;
        ZHighOut = 1'b1;
        HIin     = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign instr_cnt = cnt_q;
  assign illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_control_sequencer
// Brief    : Scoreboard bench; a reference model expands each instruction into
//            its per-cycle control words, a monitor pops one per busy cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_control_sequencer;

  localparam int CNT_W = 8;
  localparam int VW    = 16 + 16 + 14 + 5 + CNT_W;

  localparam logic [13:0] K_PCOUT  = 14'h2000;
  localparam logic [13:0] K_PCIN   = 14'h1000;
  localparam logic [13:0] K_INCPC  = 14'h0800;
  localparam logic [13:0] K_MARIN  = 14'h0400;
  localparam logic [13:0] K_MDRIN  = 14'h0200;
  localparam logic [13:0] K_READ   = 14'h0100;
  localparam logic [13:0] K_MDROUT = 14'h0080;
  localparam logic [13:0] K_IRIN   = 14'h0040;
  localparam logic [13:0] K_YIN    = 14'h0020;
  localparam logic [13:0] K_ZIN    = 14'h0010;
  localparam logic [13:0] K_ZLO    = 14'h0008;
  localparam logic [13:0] K_ZHI    = 14'h0004;
  localparam logic [13:0] K_HIIN   = 14'h0002;
  localparam logic [13:0] K_LOIN   = 14'h0001;

  logic clock = 1'b0;
  logic clear = 1'b1;
  logic run = 1'b0;
  logic mem_rdy = 1'b0;
  logic [31:0] ir = 32'h0;
`ifdef SINGLE_STEP_EN
  logic step = 1'b1;
`endif
  logic [15:0] Rin, Rout;
  logic PCout, PCin, incPC, MARin, MDRin, read, MDRout, IRin, Yin, Zin;
  logic ZLowOut, ZHighOut, HIin, LOin, busy, halted, illegal;
  logic [4:0] opcode;
  logic [CNT_W-1:0] instr_cnt;

  alu_control_sequencer #(.CNT_W(CNT_W)) dut (
    .clock(clock), .clear(clear), .run(run), .mem_rdy(mem_rdy), .ir(ir),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .Rin(Rin), .Rout(Rout), .PCout(PCout), .PCin(PCin), .incPC(incPC),
    .MARin(MARin), .MDRin(MDRin), .read(read), .MDRout(MDRout), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .ZLowOut(ZLowOut), .ZHighOut(ZHighOut), .HIin(HIin),
    .LOin(LOin), .opcode(opcode), .busy(busy), .halted(halted),
    .illegal(illegal), .instr_cnt(instr_cnt)
  );

  initial forever #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  int model_cnt = 0;
  bit model_illegal = 1'b0;
  bit model_halted = 1'b0;
  bit force_run = 1'b0;
  logic [VW-1:0] exp_q[$];
  logic [31:0]   prog_q[$];
  int            wait_q[$];

  function automatic logic [13:0] ctl_now();
    return {PCout, PCin, incPC, MARin, MDRin, read, MDRout, IRin,
            Yin, Zin, ZLowOut, ZHighOut, HIin, LOin};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // 0 undefined, 1 two-operand ALU, 2 neg/not, 3 mul/div, 4 nop, 5 halt
  function automatic int kind_of(input logic [4:0] op);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011: return 1;
      5'b10001, 5'b10010: return 2;
      5'b01111, 5'b10000: return 3;
      5'b11010: return 4;
      5'b11011: return 5;
      default:  return 0;
    endcase
  endfunction

  function automatic logic [VW-1:0] vec(input logic [15:0] rin, input logic [15:0] rout,
                                        input logic [13:0] c, input logic [4:0] opc);
    logic [31:0] cnt32;
    cnt32 = 32'(model_cnt);
    return {rin, rout, c, opc, cnt32[CNT_W-1:0]};
  endfunction

  // Expands one instruction into the control words it should produce.
  function automatic void issue(input logic [4:0] op, input logic [3:0] ra,
                                input logic [3:0] rb, input logic [3:0] rc, input int waits);
    int k;
    k = kind_of(op);
    prog_q.push_back({op, ra, rb, rc, 15'($urandom)});
    wait_q.push_back(waits);
    exp_q.push_back(vec(16'h0, 16'h0, K_PCOUT | K_MARIN | K_INCPC | K_ZIN, 5'd0));
    for (int i = 0; i <= waits; i++)
      exp_q.push_back(vec(16'h0, 16'h0, K_ZLO | K_PCIN | K_READ | K_MDRIN, 5'd0));
    exp_q.push_back(vec(16'h0, 16'h0, K_MDROUT | K_IRIN, 5'd0));
    if (k >= 1 && k <= 3) begin
      exp_q.push_back(vec(16'h0, 16'h1 << rb, K_YIN, 5'd0));
      exp_q.push_back(vec(16'h0, (k == 2) ? (16'h1 << rb) : (16'h1 << rc), K_ZIN, op));
      if (k == 3) begin
        exp_q.push_back(vec(16'h0, 16'h0, K_ZLO | K_LOIN, 5'd0));
        exp_q.push_back(vec(16'h0, 16'h0, K_ZHI | K_HIIN, 5'd0));
      end else begin
        exp_q.push_back(vec(16'h1 << ra, 16'h0, K_ZLO, 5'd0));
      end
      model_cnt++;
    end else begin
      exp_q.push_back(vec(16'h0, 16'h0, 14'h0, 5'd0));
      if (k == 0) model_illegal = 1'b1;
      else model_cnt++;
      if (k == 5) model_halted = 1'b1;
    end
  endfunction

  // Memory/IR/run driver: reacts to the DUT's fetch handshake.
  initial begin
    int cur_wait;
    cur_wait = 0;
    forever begin
      @(negedge clock);
      if (PCout) cur_wait = (wait_q.size() != 0) ? wait_q.pop_front() : 0;
      if (read) begin
        mem_rdy = (cur_wait == 0);
        if (cur_wait > 0) cur_wait--;
      end else begin
        mem_rdy = 1'($urandom_range(0, 1));
      end
      if (IRin && prog_q.size() != 0) ir = prog_q.pop_front();
      run = (prog_q.size() != 0) || force_run;
    end
  end

  // Monitor: one expected control word per busy cycle.
  initial begin
    logic [VW-1:0] act, req;
    forever begin
      @(negedge clock);
      if (busy) begin
        act = {Rin, Rout, ctl_now(), opcode, instr_cnt};
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_underflow: got 0x%0h, expected no busy cycle", act);
        end else begin
          req = exp_q.pop_front();
          if (act !== req) begin
            n_fail++;
            $display("FAIL scoreboard: got 0x%0h, expected 0x%0h", act, req);
          end
        end
      end
    end
  end

  task automatic wait_idle(input string name, input int budget);
    int i;
    i = 0;
    while ((busy || run || prog_q.size() != 0) && i < budget) begin
      @(negedge clock); #1;
      i++;
    end
    check({name, "_timeout"}, 64'(i < budget), 64'(1));
    check({name, "_drained"}, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic run_lat(input string name, input logic [4:0] op, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [3:0] rc, input int waits,
                         input int cycles);
    int t, n;
    t = 0;
    n = 0;
    issue(op, ra, rb, rc, waits);
    while (!busy && t < 50) begin @(negedge clock); #1; t++; end
    while (busy && n < 50) begin @(negedge clock); #1; n++; end
    check(name, 64'(n), 64'(cycles));
    wait_idle(name, 100);
  endtask

  function automatic void model_clear();
    exp_q.delete();
    prog_q.delete();
    wait_q.delete();
    model_cnt = 0;
    model_illegal = 1'b0;
    model_halted = 1'b0;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] legal_ops [14];
    logic [4:0] op;
    int t;
    legal_ops = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
                  5'b01010, 5'b01011, 5'b01111, 5'b10000, 5'b10001, 5'b10010, 5'b11010};

    #13;
    check("reset_ctl", {Rin, Rout, ctl_now(), opcode}, '0);
    check("reset_flags", {busy, halted, illegal}, '0);
    check("reset_cnt", 64'(instr_cnt), 64'(0));
    @(negedge clock); #2 clear = 1'b0;
    @(negedge clock); #1;
    check("idle_no_run", 64'(busy), 64'(0));

    // add R4,R3,R7 (ir 0x1A1B8000 fields), single shot, run drops mid-instruction
    run_lat("lat_add", 5'b00011, 4'd4, 4'd3, 4'd7, 0, 6);
    check("cnt_after_add", 64'(instr_cnt), 64'(1));
    run_lat("lat_add_wait3", 5'b00011, 4'd2, 4'd5, 4'd9, 3, 9);
    run_lat("lat_mul", 5'b01111, 4'd0, 4'd1, 4'd2, 0, 7);
    run_lat("lat_nop", 5'b11010, 4'd0, 4'd0, 4'd0, 0, 4);
    run_lat("lat_not", 5'b10010, 4'd15, 4'd15, 4'd15, 1, 7);
    check("cnt_after_directed", 64'(instr_cnt), 64'(model_cnt % (1 << CNT_W)));
    check("no_illegal_yet", 64'(illegal), 64'(0));

    // undefined opcode: flagged, not counted, back to IDLE
    run_lat("lat_illegal", 5'b11111, 4'd1, 4'd2, 4'd3, 0, 4);
    check("illegal_set", 64'(illegal), 64'(1));
    check("illegal_no_count", 64'(instr_cnt), 64'(model_cnt % (1 << CNT_W)));

    // clear during T4
    issue(5'b00011, 4'd4, 4'd3, 4'd7, 0);
    t = 0;
    while (opcode == 5'd0 && t < 50) begin @(negedge clock); #1; t++; end
    check("clear_reach_t4", 64'(opcode), 64'(5'b00011));
    clear = 1'b1;
    model_clear();
    #1;
    check("clear_ctl", {Rin, Rout, ctl_now(), opcode}, '0);
    check("clear_flags", {busy, halted, illegal}, '0);
    check("clear_cnt", 64'(instr_cnt), 64'(0));
    @(posedge clock); @(negedge clock); #2 clear = 1'b0;

    // random back-to-back burst, long enough to wrap the counter
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) < 5) begin
        do op = 5'($urandom); while (kind_of(op) != 0);
      end else begin
        op = legal_ops[$urandom_range(0, 13)];
      end
      issue(op, 4'($urandom), 4'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
    end
    wait_idle("burst", 5000);
    check("burst_cnt_wrap", 64'(instr_cnt), 64'(model_cnt % (1 << CNT_W)));
    check("burst_illegal", 64'(illegal), 64'(model_illegal));
    check("burst_wrapped", 64'(model_cnt >= (1 << CNT_W)), 64'(1));

    // nop then halt, then run is ignored until clear
    issue(5'b11010, 4'd0, 4'd0, 4'd0, 1);
    issue(5'b11011, 4'd0, 4'd0, 4'd0, 0);
    wait_idle("halt", 100);
    check("halted", 64'(halted), 64'(model_halted));
    check("halt_cnt", 64'(instr_cnt), 64'(model_cnt % (1 << CNT_W)));
    force_run = 1'b1;
    repeat (6) @(negedge clock);
    #1;
    check("halt_holds", {busy, halted}, 64'(2'b01));
    force_run = 1'b0;
    clear = 1'b1;
    model_clear();
    #1;
    check("halt_cleared", {busy, halted, illegal}, '0);
    @(negedge clock); #2 clear = 1'b0;
    run_lat("lat_after_halt", 5'b10000, 4'd3, 4'd4, 4'd5, 2, 9);
    check("cnt_after_halt", 64'(instr_cnt), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
